// File: rtl/data_mem_resp_if.sv
// Load/store bus between the pipeline MEM stage (master) and the
// data-memory responder (slave).
//
// Handshake: the master raises mem_ce_i with we/addr/sel/data and must hold
// all of them stable for as long as stall_req_o is high. The cycle in which
// stall_req_o falls with mem_ce_i still high is the completion cycle. Read
// data (mem_data_o) and the error pulse (err_o) are valid in that cycle.
// Dropping mem_ce_i while stalled abandons the access.
interface data_mem_resp_if;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        stall_req_o;
  logic        err_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, stall_req_o, err_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, stall_req_o, err_o
  );
endinterface

// File: rtl/data_mem_resp.sv
// Data-memory responder: serves MEM-stage loads/stores from an on-chip word
// array after WAIT_CYCLES stall cycles. Reads return the full 32-bit word.
// Writes update only the byte lanes selected by mem_sel_i. Bad requests
// (no lanes selected, or an address beyond the array) complete with a
// one-cycle err_o pulse and leave the array untouched.
module data_mem_resp #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_CYCLES = 2   // legal range 1..15
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_resp_if.slave  bus,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  state_t                state;
  logic [3:0]            counter;
  logic [31:0]           mem_array [DEPTH];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  addr_oob;
  logic                  acc_err;
  logic                  commit;
  logic                  wr_commit;

  assign word_idx = bus.mem_addr_i[ADDR_WIDTH+1:2];
  // Any address bit above the array span makes the access an error,
  // so an out-of-range store can never wrap onto a low word.
  assign addr_oob = (bus.mem_addr_i >> (ADDR_WIDTH + 2)) != 32'd0;
  assign acc_err  = (bus.mem_sel_i == 4'd0) || addr_oob;

  // The edge that enters DONE is the single commit point of an access.
  assign commit = !rst && bus.mem_ce_i &&
                  (((state == IDLE) && (WAIT_CYCLES == 1)) ||
                   ((state == WAIT) && (counter == 4'd1)));
  assign wr_commit = commit && bus.mem_we_i && !acc_err;

  // The stall is held while a live request is pending. It is never held in
  // DONE, and it drops at once when the requester withdraws mem_ce_i.
  assign bus.stall_req_o = !rst && bus.mem_ce_i &&
                           ((state == IDLE) || (state == WAIT));

  assign dbg_state = state;

  // Access sequencer: counts the wait states, commits the read data and the
  // error pulse, and handles aborts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      counter        <= 4'd0;
      bus.mem_data_o <= 32'd0;
      bus.err_o      <= 1'b0;
    end else begin
      bus.err_o <= commit ? acc_err : 1'b0;
      if (commit && !bus.mem_we_i) begin
        bus.mem_data_o <= acc_err ? 32'd0 : mem_array[word_idx];
      end
      case (state)
        IDLE: begin
          if (bus.mem_ce_i) begin
            if (WAIT_CYCLES == 1) begin
              state <= DONE;
            end else begin
              state   <= WAIT;
              counter <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (!bus.mem_ce_i) begin
            state   <= IDLE;
            counter <= 4'd0;
          end else if (counter == 4'd1) begin
            state   <= DONE;
            counter <= 4'd0;
          end else begin
            counter <= counter - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          counter <= 4'd0;
        end
      endcase
    end
  end

  // Byte-lane store into the array. The array is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_commit && bus.mem_sel_i[k]) begin
        mem_array[word_idx][8*k +: 8] <= bus.mem_data_i[8*k +: 8];
      end
    end
  end

endmodule
